// File: rtl/uop_bist_pkg.sv
// Shared types and helpers for the truth-table sweep engine (logic BIST).
// Holds the FSM state encoding and the settle-counter width function.
package uop_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // A one-cycle settle still needs a one-bit counter, hence the clamp.
    function automatic int cnt_width(input int settle);
        int w;
        w = $clog2(settle);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/uop_minterm_checker_if.sv
// Bus between the sweep engine (master) and the DUT/board side (slave).
// Carries the start request, driven minterm, DUT output and sweep results.
interface uop_minterm_checker_if #(
    parameter int N = 2
);
    logic         start;
    logic [N-1:0] stim;
    logic         dut_y;
    logic         busy;
    logic         done;
    logic         pass;
    logic [N:0]   fail_count;
    logic [N-1:0] first_fail;
    logic         first_fail_valid;

    modport master (
        input  start, dut_y,
        output stim, busy, done, pass, fail_count, first_fail, first_fail_valid
    );

    modport slave (
        output start, dut_y,
        input  stim, busy, done, pass, fail_count, first_fail, first_fail_valid
    );
endinterface

// File: rtl/uop_settle_timer.sv
// Settle counter for the DRIVE state: counts enabled cycles from zero and
// flags the cycle on which SETTLE cycles have elapsed.
module uop_settle_timer
    import uop_bist_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = cnt_width(SETTLE);

    logic [W-1:0] cnt_q, cnt_d;

    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && (cnt_q == W'(SETTLE - 1));

endmodule

// File: rtl/uop_minterm_checker.sv
// Truth-table sweep engine: drives minterms 0..2**N-1, compares dut_y to TRUTH.
// Define UOP_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module uop_minterm_checker
    import uop_bist_pkg::*;
#(
    parameter int                 N      = 2,
    parameter int                 SETTLE = 1,
    parameter logic [(1<<N)-1:0]  TRUTH  = 4'b1001
) (
    input  logic                  clk,
    input  logic                  reset,
    uop_minterm_checker_if.master bus
);
    state_t       state_q, state_d;
    logic [N-1:0] stim_q, stim_d;
    logic [N:0]   fail_count_q, fail_count_d;
    logic [N-1:0] first_fail_q, first_fail_d;
    logic         first_fail_valid_q, first_fail_valid_d;

    logic timer_clear;
    logic timer_enable;
    logic timer_expired;
    logic mismatch;
    logic last_minterm;

    uop_settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    assign timer_enable = (state_q == DRIVE);
    assign timer_clear  = (state_q != DRIVE);
    assign mismatch     = (bus.dut_y != TRUTH[stim_q]);
    assign last_minterm = (stim_q == {N{1'b1}});

    always_comb begin
        state_d            = state_q;
        stim_d             = stim_q;
        fail_count_d       = fail_count_q;
        first_fail_d       = first_fail_q;
        first_fail_valid_d = first_fail_valid_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d            = DRIVE;
                    stim_d             = '0;
                    fail_count_d       = '0;
                    first_fail_d       = '0;
                    first_fail_valid_d = 1'b0;
                end
            end
            DRIVE: begin
                if (timer_expired) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    fail_count_d = fail_count_q + (N+1)'(1);
                    if (!first_fail_valid_q) begin
                        first_fail_d       = stim_q;
                        first_fail_valid_d = 1'b1;
                    end
                end
`ifdef UOP_STOP_ON_FAIL_EN
                if (mismatch || last_minterm) begin
                    state_d = DONE;
                end else begin
                    stim_d  = stim_q + N'(1);
                    state_d = DRIVE;
                end
`else
                if (last_minterm) begin
                    state_d = DONE;
                end else begin
                    stim_d  = stim_q + N'(1);
                    state_d = DRIVE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q            <= IDLE;
            stim_q             <= '0;
            fail_count_q       <= '0;
            first_fail_q       <= '0;
            first_fail_valid_q <= 1'b0;
        end else begin
            state_q            <= state_d;
            stim_q             <= stim_d;
            fail_count_q       <= fail_count_d;
            first_fail_q       <= first_fail_d;
            first_fail_valid_q <= first_fail_valid_d;
        end
    end

    assign bus.stim             = stim_q;
    assign bus.busy             = (state_q == DRIVE) || (state_q == CHECK);
    assign bus.done             = (state_q == DONE);
    assign bus.pass             = (state_q == DONE) && (fail_count_q == '0);
    assign bus.fail_count       = fail_count_q;
    assign bus.first_fail       = first_fail_q;
    assign bus.first_fail_valid = first_fail_valid_q;

endmodule

// File: tb/tb_uop_minterm_checker.sv
// Directed bench for uop_minterm_checker: N=2/SETTLE=1 and N=3/SETTLE=3 instances,
// with XNOR, XOR and single-fault gate models selected by dut_mode.
module tb_uop_minterm_checker;
    import uop_bist_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   dut_mode;   // 0: XNOR, 1: XOR, 2: XNOR wrong at minterm 2
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    uop_minterm_checker_if #(.N(2)) bus2 ();
    uop_minterm_checker_if #(.N(3)) bus3 ();

    assign bus2.dut_y = (dut_mode == 1) ? ^bus2.stim :
                        ((dut_mode == 2) && (bus2.stim == 2'd2)) ? ^bus2.stim :
                        ~^bus2.stim;
    assign bus3.dut_y = ^bus3.stim;

    uop_minterm_checker #(.N(2), .SETTLE(1), .TRUTH(4'b1001)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.master)
    );

    uop_minterm_checker #(.N(3), .SETTLE(3), .TRUTH(8'b1001_0110)) u_wide (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3.master)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Start a sweep on the N=2 instance and count edges until done.
    // stim_err counts edges where stim differs from the full-sweep schedule.
    task automatic run2(input bit hold_start, input int pulse_edge,
                        output int edges, output int stim_err);
        int exp_stim;
        bus2.start = 1'b1;
        @(posedge clk); #1;
        if (!hold_start) bus2.start = 1'b0;
        edges    = 0;
        stim_err = 0;
        while (edges < 100) begin
            @(posedge clk); #1;
            edges++;
            if (!hold_start) bus2.start = (edges == pulse_edge);
            exp_stim = (edges / 2 > 3) ? 3 : edges / 2;
            if (int'(bus2.stim) != exp_stim) stim_err++;
            if (bus2.done) break;
        end
    endtask

    task automatic wait_done2();
        int n = 0;
        while (!bus2.done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_done_bound", 32'(bus2.done), 1);
    endtask

    initial begin
        int edges;
        int stim_err;

        reset      = 1'b1;
        bus2.start = 1'b0;
        bus3.start = 1'b0;
        dut_mode   = 0;
        #1;
        check("rst_stim",  32'(bus2.stim), 0);
        check("rst_busy",  32'(bus2.busy), 0);
        check("rst_done",  32'(bus2.done), 0);
        check("rst_pass",  32'(bus2.pass), 0);
        check("rst_fcnt",  32'(bus2.fail_count), 0);
        check("rst_ffv",   32'(bus2.first_fail_valid), 0);
        check("rst_state", 32'(u_dut.state_q), 32'(IDLE));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Good XNOR DUT
        dut_mode = 0;
        run2(1'b0, 0, edges, stim_err);
        check("good_done_edge", 32'(edges), 8);
        check("good_stim_seq",  32'(stim_err), 0);
        check("good_pass",      32'(bus2.pass), 1);
        check("good_fcnt",      32'(bus2.fail_count), 0);
        check("good_ffv",       32'(bus2.first_fail_valid), 0);
        check("good_busy",      32'(bus2.busy), 0);
        repeat (2) @(posedge clk);
        #1;
        check("good_done_hold", 32'(bus2.done), 1);
        check("good_stim_hold", 32'(bus2.stim), 3);

        // Wrong gate (XOR)
        dut_mode = 1;
        run2(1'b0, 0, edges, stim_err);
`ifdef UOP_STOP_ON_FAIL_EN
        check("xor_done_edge", 32'(edges), 2);
        check("xor_fcnt",      32'(bus2.fail_count), 1);
`else
        check("xor_done_edge", 32'(edges), 8);
        check("xor_fcnt",      32'(bus2.fail_count), 4);
`endif
        check("xor_ff",   32'(bus2.first_fail), 0);
        check("xor_ffv",  32'(bus2.first_fail_valid), 1);
        check("xor_pass", 32'(bus2.pass), 0);

        // start in DONE restarts and clears results on the accept edge
        bus2.start = 1'b1;
        @(posedge clk); #1;
        bus2.start = 1'b0;
        check("restart_busy", 32'(bus2.busy), 1);
        check("restart_fcnt", 32'(bus2.fail_count), 0);
        check("restart_ffv",  32'(bus2.first_fail_valid), 0);
        check("restart_stim", 32'(bus2.stim), 0);

        // Reset mid-sweep at cycle 3
        repeat (3) @(posedge clk);
        #1;
        check("mid_busy_pre", 32'(bus2.busy), 1);
        reset = 1'b1;
        #1;
        check("mid_rst_stim",  32'(bus2.stim), 0);
        check("mid_rst_busy",  32'(bus2.busy), 0);
        check("mid_rst_done",  32'(bus2.done), 0);
        check("mid_rst_fcnt",  32'(bus2.fail_count), 0);
        check("mid_rst_ffv",   32'(bus2.first_fail_valid), 0);
        check("mid_rst_state", 32'(u_dut.state_q), 32'(IDLE));
        @(negedge clk);
        reset    = 1'b0;
        dut_mode = 0;
        run2(1'b0, 0, edges, stim_err);
        check("post_rst_done_edge", 32'(edges), 8);
        check("post_rst_pass",      32'(bus2.pass), 1);

        // Single fault at minterm 2
        dut_mode = 2;
        run2(1'b0, 0, edges, stim_err);
`ifdef UOP_STOP_ON_FAIL_EN
        check("fault_done_edge", 32'(edges), 6);
`else
        check("fault_done_edge", 32'(edges), 8);
`endif
        check("fault_fcnt", 32'(bus2.fail_count), 1);
        check("fault_ff",   32'(bus2.first_fail), 2);
        check("fault_ffv",  32'(bus2.first_fail_valid), 1);
        check("fault_pass", 32'(bus2.pass), 0);

        // start held high throughout: no restart while busy
        dut_mode = 0;
        run2(1'b1, 0, edges, stim_err);
        check("hold_done_edge", 32'(edges), 8);
        check("hold_stim_seq",  32'(stim_err), 0);
        @(posedge clk); #1;
        check("hold_rearm_busy", 32'(bus2.busy), 1);
        bus2.start = 1'b0;
        wait_done2();

        // start pulsed during busy: ignored
        run2(1'b0, 3, edges, stim_err);
        check("pulse_done_edge", 32'(edges), 8);
        check("pulse_stim_seq",  32'(stim_err), 0);
        check("pulse_pass",      32'(bus2.pass), 1);

        // Simultaneous reset and start: reset wins
        reset      = 1'b1;
        bus2.start = 1'b1;
        @(posedge clk); #1;
        check("rst_start_busy", 32'(bus2.busy), 0);
        check("rst_start_done", 32'(bus2.done), 0);
        bus2.start = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Wider config: N=3, SETTLE=3, 3-input XOR
        begin
            int e = 0;
            int serr = 0;
            int exp_stim;
            @(negedge clk);
            bus3.start = 1'b1;
            @(posedge clk); #1;
            bus3.start = 1'b0;
            while (e < 200) begin
                @(posedge clk); #1;
                e++;
                exp_stim = (e / 4 > 7) ? 7 : e / 4;
                if (int'(bus3.stim) != exp_stim) serr++;
                if (bus3.done) break;
            end
            check("wide_done_edge", 32'(e), 32);
            check("wide_stim_seq",  32'(serr), 0);
            check("wide_pass",      32'(bus3.pass), 1);
            check("wide_fcnt",      32'(bus3.fail_count), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
